// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit:
// state encoding, ALU/select codes, opcode/func values and the decoded instruction class.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;
    localparam logic [3:0] ALU_SLT = 4'b1001;

    localparam logic [1:0] ALUB_RT   = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_BOFF = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_RS     = 2'b10;
    localparam logic [1:0] PCS_JUMP   = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic is_add;  logic is_sub;  logic is_and;  logic is_or;
        logic is_xor;  logic is_sll;  logic is_srl;  logic is_sra;
        logic is_slt;  logic is_jr;   logic is_addi; logic is_andi;
        logic is_ori;  logic is_xori; logic is_lw;   logic is_sw;
        logic is_beq;  logic is_bne;  logic is_lui;  logic is_j;
        logic is_jal;
    } instr_t;

    // Classes are one-hot, so the ALU code is an OR of masked constants.
    function automatic logic [3:0] alu_code(input instr_t d);
        return ({4{d.is_add | d.is_addi | d.is_lw | d.is_sw}} & ALU_ADD)
             | ({4{d.is_sub | d.is_beq | d.is_bne}}           & ALU_SUB)
             | ({4{d.is_and | d.is_andi}}                     & ALU_AND)
             | ({4{d.is_or  | d.is_ori}}                      & ALU_OR)
             | ({4{d.is_xor | d.is_xori}}                     & ALU_XOR)
             | ({4{d.is_lui}}                                 & ALU_LUI)
             | ({4{d.is_sll}}                                 & ALU_SLL)
             | ({4{d.is_srl}}                                 & ALU_SRL)
             | ({4{d.is_sra}}                                 & ALU_SRA)
             | ({4{d.is_slt}}                                 & ALU_SLT);
    endfunction

endpackage

// File: rtl/mc_cu_if.sv
// Control-unit bundle: IR fields, ALU flag and memory handshake in; datapath enables out.
// Valid/ready: mem_ready high in IF or MEM means the access completes this cycle.
interface mc_cu_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       mem_ready;
    logic       wpc;
    logic       wir;
    logic       wmem;
    logic       wreg;
    logic       iord;
    logic       regrt;
    logic       m2reg;
    logic       jal;
    logic       sext;
    logic       shift;
    logic       alua;
    logic [1:0] alub;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic [2:0] state;
    logic       illegal;
    logic       mem_timeout;

    modport master (
        input  op, func, z, mem_ready,
        output wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
               alua, alub, aluc, pcsource, state, illegal, mem_timeout
    );

    modport slave (
        output op, func, z, mem_ready,
        input  wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
               alua, alub, aluc, pcsource, state, illegal, mem_timeout
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/func to one-hot instruction class plus illegal flag.
module mc_decode
    import mc_pkg::*;
#(
    parameter int ENABLE_SLT = 0
) (
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output instr_t     o_dec,
    output logic       o_illegal
);
    logic w_rtype;
    assign w_rtype = (i_op == OP_RTYPE);

    always_comb begin
        o_dec         = '0;
        o_dec.is_add  = w_rtype && (i_func == FN_ADD);
        o_dec.is_sub  = w_rtype && (i_func == FN_SUB);
        o_dec.is_and  = w_rtype && (i_func == FN_AND);
        o_dec.is_or   = w_rtype && (i_func == FN_OR);
        o_dec.is_xor  = w_rtype && (i_func == FN_XOR);
        o_dec.is_sll  = w_rtype && (i_func == FN_SLL);
        o_dec.is_srl  = w_rtype && (i_func == FN_SRL);
        o_dec.is_sra  = w_rtype && (i_func == FN_SRA);
        o_dec.is_jr   = w_rtype && (i_func == FN_JR);
        o_dec.is_slt  = (ENABLE_SLT != 0) && w_rtype && (i_func == FN_SLT);
        o_dec.is_addi = (i_op == OP_ADDI);
        o_dec.is_andi = (i_op == OP_ANDI);
        o_dec.is_ori  = (i_op == OP_ORI);
        o_dec.is_xori = (i_op == OP_XORI);
        o_dec.is_lw   = (i_op == OP_LW);
        o_dec.is_sw   = (i_op == OP_SW);
        o_dec.is_beq  = (i_op == OP_BEQ);
        o_dec.is_bne  = (i_op == OP_BNE);
        o_dec.is_lui  = (i_op == OP_LUI);
        o_dec.is_j    = (i_op == OP_J);
        o_dec.is_jal  = (i_op == OP_JAL);
    end

    // Anything that matched no class executes as a nop.
    assign o_illegal = (o_dec == '0);
endmodule

// File: rtl/mc_cu.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer with memory-ready wait and timeout.
// Control outputs are combinational from state and decoded IR; all forced low while in reset.
module mc_cu
    import mc_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_TIMEOUT   = 16,
    parameter int ENABLE_SLT    = 0
) (
    input  logic     clock,
    input  logic     resetn,
    mc_cu_if.master  bus
);
    localparam bit         HS_EN   = (MEM_HANDSHAKE != 0);
    localparam bit         TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(MEM_TIMEOUT - 1) : 8'd0;

    state_e     r_state;
    logic [7:0] r_wait_cnt;

    instr_t w_dec;
    logic   w_illegal;
    logic   w_ready;
    logic   w_waiting;
    logic   w_timeout;
    logic   w_jump_id;
    logic   w_branch;
    logic   w_memop;
    logic   w_ialu;
    logic   w_shift;
    logic   w_sext;

    mc_decode #(.ENABLE_SLT(ENABLE_SLT)) u_decode (
        .i_op      (bus.op),
        .i_func    (bus.func),
        .o_dec     (w_dec),
        .o_illegal (w_illegal)
    );

    assign w_ready   = bus.mem_ready | ~HS_EN;
    assign w_waiting = ((r_state == S_IF) || (r_state == S_MEM)) && !w_ready;
    // A ready in the expiry cycle keeps w_waiting low, so ready always wins.
    assign w_timeout = TO_EN && w_waiting && (r_wait_cnt == TO_LAST);

    assign w_jump_id = w_dec.is_j | w_dec.is_jal | w_dec.is_jr;
    assign w_branch  = w_dec.is_beq | w_dec.is_bne;
    assign w_memop   = w_dec.is_lw | w_dec.is_sw;
    assign w_ialu    = w_dec.is_addi | w_dec.is_andi | w_dec.is_ori | w_dec.is_xori | w_dec.is_lui;
    assign w_shift   = w_dec.is_sll | w_dec.is_srl | w_dec.is_sra;
    assign w_sext    = w_dec.is_addi | w_memop | w_branch;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IF;
            r_wait_cnt <= '0;
        end else if (w_timeout) begin
            // IF timeout leaves the PC untouched, so the fetch simply retries.
            r_state    <= S_IF;
            r_wait_cnt <= '0;
        end else begin
            if (w_waiting)
                r_wait_cnt <= (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
            else
                r_wait_cnt <= '0;
            case (r_state)
                S_IF:    if (w_ready) r_state <= S_ID;
                S_ID:    r_state <= (w_jump_id || w_illegal) ? S_IF : S_EXE;
                S_EXE:   r_state <= w_branch ? S_IF : (w_memop ? S_MEM : S_WB);
                S_MEM:   if (w_ready) r_state <= w_dec.is_lw ? S_WB : S_IF;
                S_WB:    r_state <= S_IF;
                default: r_state <= S_IF;
            endcase
        end
    end

    always_comb begin
        bus.wpc         = 1'b0;
        bus.wir         = 1'b0;
        bus.wmem        = 1'b0;
        bus.wreg        = 1'b0;
        bus.iord        = 1'b0;
        bus.regrt       = 1'b0;
        bus.m2reg       = 1'b0;
        bus.jal         = 1'b0;
        bus.sext        = 1'b0;
        bus.shift       = 1'b0;
        bus.alua        = 1'b0;
        bus.alub        = ALUB_RT;
        bus.aluc        = ALU_ADD;
        bus.pcsource    = PCS_ALU;
        bus.state       = S_IF;
        bus.illegal     = 1'b0;
        bus.mem_timeout = 1'b0;
        if (resetn) begin
            bus.state       = r_state;
            bus.mem_timeout = w_timeout;
            case (r_state)
                S_IF: begin
                    bus.wpc  = w_ready;
                    bus.wir  = w_ready;
                    bus.alub = ALUB_FOUR;
                end
                S_ID: begin
                    // Branch target is precomputed into ALUOUT here for every instruction.
                    bus.alub    = ALUB_BOFF;
                    bus.sext    = 1'b1;
                    bus.illegal = w_illegal;
                    if (w_dec.is_j || w_dec.is_jal) begin
                        bus.wpc      = 1'b1;
                        bus.pcsource = PCS_JUMP;
                    end
                    if (w_dec.is_jal) begin
                        bus.wreg = 1'b1;
                        bus.jal  = 1'b1;
                    end
                    if (w_dec.is_jr) begin
                        bus.wpc      = 1'b1;
                        bus.pcsource = PCS_RS;
                    end
                end
                S_EXE: begin
                    bus.shift = w_shift;
                    bus.alua  = ~w_shift;
                    bus.aluc  = alu_code(w_dec);
                    bus.sext  = w_sext;
                    bus.alub  = (w_ialu || w_memop) ? ALUB_IMM : ALUB_RT;
                    if (w_branch) begin
                        bus.wpc      = (w_dec.is_beq & bus.z) | (w_dec.is_bne & ~bus.z);
                        bus.pcsource = PCS_ALUOUT;
                    end
                end
                S_MEM: begin
                    bus.iord = 1'b1;
                    bus.wmem = w_dec.is_sw & w_ready;
                end
                S_WB: begin
                    bus.wreg  = 1'b1;
                    bus.m2reg = w_dec.is_lw;
                    bus.regrt = w_ialu | w_dec.is_lw;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_cu.sv
// Bench for mc_cu: a phase-list model of each instruction produces the expected
// per-cycle control vector; two DUTs cover the default and the short-timeout/slt builds.
module tb_mc_cu;
    localparam int W = 24;

    localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4;

    localparam int K_ADD = 0,  K_SUB = 1,  K_AND = 2,  K_OR = 3,   K_XOR = 4,  K_SLL = 5;
    localparam int K_SRL = 6,  K_SRA = 7,  K_SLT = 8,  K_JR = 9,   K_ADDI = 10, K_ANDI = 11;
    localparam int K_ORI = 12, K_XORI = 13, K_LW = 14, K_SW = 15,  K_BEQ = 16, K_BNE = 17;
    localparam int K_LUI = 18, K_J = 19,   K_JAL = 20, K_ILL = 21;

    logic [5:0] op_tab [22] = '{
        6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
        6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b001100,
        6'b001101, 6'b001110, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
        6'b001111, 6'b000010, 6'b000011, 6'b111111};
    logic [5:0] fn_tab [22] = '{
        6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b000000,
        6'b000010, 6'b000011, 6'b101010, 6'b001000, 6'b0, 6'b0,
        6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
    logic [3:0] aluc_tab [22] = '{
        4'h0, 4'h4, 4'h1, 4'h5, 4'h2, 4'h3, 4'h7, 4'hF, 4'h9, 4'h0, 4'h0,
        4'h1, 4'h5, 4'h2, 4'h0, 4'h0, 4'h4, 4'h4, 4'h6, 4'h0, 4'h0, 4'h0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_cu_if bus_a ();
    mc_cu_if bus_b ();

    mc_cu #(.MEM_HANDSHAKE(1), .MEM_TIMEOUT(16), .ENABLE_SLT(0)) dut_a (
        .clock(clk), .resetn(rst_n), .bus(bus_a));
    mc_cu #(.MEM_HANDSHAKE(1), .MEM_TIMEOUT(4), .ENABLE_SLT(1)) dut_b (
        .clock(clk), .resetn(rst_n), .bus(bus_b));

    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_q[$];
    logic         rdy_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] exp_vec(input int ph, input int k, input logic zz,
                                             input logic rdy, input logic tmo);
        logic wpc, wir, wmem, wreg, iord, regrt, m2reg, jl, sext, shift, alua, ill;
        logic [1:0] alub, pcs;
        logic [3:0] aluc;
        logic [2:0] st;
        bit ialu;
        ialu = k inside {K_ADDI, K_ANDI, K_ORI, K_XORI, K_LUI};
        {wpc, wir, wmem, wreg, iord, regrt, m2reg, jl, sext, shift, alua, ill} = '0;
        alub = 2'b00; pcs = 2'b00; aluc = 4'h0;
        st = 3'(ph);
        case (ph)
            P_IF: begin wpc = rdy; wir = rdy; alub = 2'b01; end
            P_ID: begin
                alub = 2'b11; sext = 1'b1;
                if (k == K_J || k == K_JAL) begin wpc = 1'b1; pcs = 2'b11; end
                if (k == K_JAL) begin wreg = 1'b1; jl = 1'b1; end
                if (k == K_JR) begin wpc = 1'b1; pcs = 2'b10; end
                if (k == K_ILL) ill = 1'b1;
            end
            P_EXE: begin
                shift = k inside {K_SLL, K_SRL, K_SRA};
                alua  = !shift;
                aluc  = aluc_tab[k];
                sext  = k inside {K_ADDI, K_LW, K_SW, K_BEQ, K_BNE};
                alub  = (ialu || k == K_LW || k == K_SW) ? 2'b10 : 2'b00;
                if (k == K_BEQ) wpc = zz;
                if (k == K_BNE) wpc = !zz;
                if (k == K_BEQ || k == K_BNE) pcs = 2'b01;
            end
            P_MEM: begin iord = 1'b1; wmem = (k == K_SW) && rdy; end
            P_WB: begin wreg = 1'b1; m2reg = (k == K_LW); regrt = ialu || (k == K_LW); end
            default: ;
        endcase
        return {st, wpc, wir, wmem, wreg, iord, regrt, m2reg, jl, sext, shift, alua,
                alub, aluc, pcs, ill, tmo};
    endfunction

    // Walks the instruction's phase list; if_stall/mem_stall are not-ready cycles in IF/MEM.
    task automatic build_model(input int k, input logic zz, input int if_stall,
                               input int mem_stall, input int to, input bit slt_en);
        int ek, p, left, wait_c, phase;
        int ph[$];
        logic rdy, tmo;
        bit done;
        ek = (k == K_SLT && !slt_en) ? K_ILL : k;
        if (ek inside {K_J, K_JAL, K_JR, K_ILL}) ph = '{P_IF, P_ID};
        else if (ek inside {K_BEQ, K_BNE})      ph = '{P_IF, P_ID, P_EXE};
        else if (ek == K_SW)                    ph = '{P_IF, P_ID, P_EXE, P_MEM};
        else if (ek == K_LW)                    ph = '{P_IF, P_ID, P_EXE, P_MEM, P_WB};
        else                                    ph = '{P_IF, P_ID, P_EXE, P_WB};
        p = 0; left = if_stall; wait_c = 0; done = 1'b0;
        while (!done && p < ph.size()) begin
            phase = ph[p];
            if (phase == P_IF || phase == P_MEM) begin
                rdy = (left == 0);
                tmo = !rdy && (to != 0) && (wait_c == to - 1);
                exp_q.push_back(exp_vec(phase, ek, zz, rdy, tmo));
                rdy_q.push_back(rdy);
                if (rdy) begin
                    p++; wait_c = 0;
                end else begin
                    left--;
                    if (tmo) begin
                        wait_c = 0;
                        if (phase == P_MEM) done = 1'b1;
                    end else begin
                        wait_c++;
                    end
                end
            end else begin
                rdy = 1'($urandom_range(0, 1));
                exp_q.push_back(exp_vec(phase, ek, zz, rdy, 1'b0));
                rdy_q.push_back(rdy);
                p++;
                if (p < ph.size() && ph[p] == P_MEM) left = mem_stall;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input int dut, input logic [5:0] o, input logic [5:0] f,
                          input logic zz, input logic r);
        if (dut == 0) begin
            bus_a.op = o; bus_a.func = f; bus_a.z = zz; bus_a.mem_ready = r;
        end else begin
            bus_b.op = o; bus_b.func = f; bus_b.z = zz; bus_b.mem_ready = r;
        end
    endtask

    function automatic logic [W-1:0] sample(input int dut);
        if (dut == 0)
            return {bus_a.state, bus_a.wpc, bus_a.wir, bus_a.wmem, bus_a.wreg, bus_a.iord,
                    bus_a.regrt, bus_a.m2reg, bus_a.jal, bus_a.sext, bus_a.shift, bus_a.alua,
                    bus_a.alub, bus_a.aluc, bus_a.pcsource, bus_a.illegal, bus_a.mem_timeout};
        return {bus_b.state, bus_b.wpc, bus_b.wir, bus_b.wmem, bus_b.wreg, bus_b.iord,
                bus_b.regrt, bus_b.m2reg, bus_b.jal, bus_b.sext, bus_b.shift, bus_b.alua,
                bus_b.alub, bus_b.aluc, bus_b.pcsource, bus_b.illegal, bus_b.mem_timeout};
    endfunction

    // Called at a falling edge; one loop pass per model cycle, ends on a falling edge.
    task automatic drive(input int dut, input int k, input logic zz);
        logic [5:0] fn;
        logic r;
        fn = (k <= K_JR) ? fn_tab[k] : 6'($urandom);
        while (rdy_q.size() > 0) begin
            r = rdy_q.pop_front();
            set_in(dut, op_tab[k], fn, zz, r);
            #1;
            act_q.push_back(sample(dut));
            @(negedge clk);
        end
    endtask

    task automatic run(input int dut, input int k, input logic zz, input int if_stall,
                       input int mem_stall);
        build_model(k, zz, if_stall, mem_stall, (dut == 0) ? 16 : 4, dut != 0);
        drive(dut, k, zz);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 6'd0, 6'd0, 1'b0, 1'b0);
        set_in(1, 6'd0, 6'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] a;
        rst_n = 1'b0;
        set_in(0, 6'b000000, 6'b100000, 1'b1, 1'b1);
        set_in(1, 6'b000000, 6'b100000, 1'b1, 1'b1);
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            a = sample(d);
            n_checks++;
            if (a !== '0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h expected %h", d, a, {W{1'b0}});
            end
        end
        do_reset();
    endtask

    task automatic test_add();
        logic [W-1:0] e, a;
        int i = 0;
        do_reset();
        run(0, K_ADD, 1'b0, 0, 0);
        run(0, K_SUB, 1'b1, 1, 0);
        run(0, K_SLL, 1'b0, 0, 0);
        run(0, K_ORI, 1'b0, 0, 0);
        run(0, K_LUI, 1'b0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL alu cycle %0d: got %h expected %h", i, a, e); end
            i++;
        end
    endtask

    task automatic test_mem_stall();
        logic [W-1:0] e, a;
        int i = 0;
        do_reset();
        run(0, K_LW, 1'b0, 0, 3);
        run(0, K_SW, 1'b0, 2, 2);
        run(0, K_LW, 1'b1, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL mem_stall cycle %0d: got %h expected %h", i, a, e); end
            i++;
        end
    endtask

    task automatic test_branch_jump();
        logic [W-1:0] e, a;
        int i = 0;
        do_reset();
        run(0, K_BEQ, 1'b1, 0, 0);
        run(0, K_BEQ, 1'b0, 0, 0);
        run(0, K_BNE, 1'b0, 0, 0);
        run(0, K_BNE, 1'b1, 0, 0);
        run(0, K_JAL, 1'b0, 0, 0);
        run(0, K_J, 1'b0, 0, 0);
        run(0, K_JR, 1'b0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL branch_jump cycle %0d: got %h expected %h", i, a, e); end
            i++;
        end
        a = sample(0);
        n_checks++;
        if (a[W-1 -: 3] !== 3'd0) begin
            n_fail++; $display("FAIL after_jr state: got %0d expected 0", a[W-1 -: 3]);
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] e, a;
        int i = 0;
        do_reset();
        run(1, K_SW, 1'b0, 0, 6);
        run(1, K_LW, 1'b0, 0, 5);
        run(1, K_ADD, 1'b0, 5, 0);
        run(1, K_SW, 1'b0, 0, 3);
        run(1, K_LW, 1'b0, 3, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL timeout cycle %0d: got %h expected %h", i, a, e); end
            i++;
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] e, a;
        int i = 0;
        do_reset();
        run(0, K_ILL, 1'b0, 0, 0);
        run(0, K_SLT, 1'b0, 0, 0);
        run(0, K_ADD, 1'b0, 0, 0);
        do_reset();
        run(1, K_SLT, 1'b0, 0, 0);
        run(1, K_ILL, 1'b1, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL illegal cycle %0d: got %h expected %h", i, a, e); end
            i++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e, a;
        int i = 0;
        int k, is_, ms;
        logic zz;
        for (int d = 0; d < 2; d++) begin
            do_reset();
            for (int n = 0; n < 40; n++) begin
                k   = $urandom_range(0, 21);
                zz  = 1'($urandom_range(0, 1));
                is_ = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (d == 0) ? 6 : 9) : 0;
                ms  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (d == 0) ? 6 : 9) : 0;
                run(d, k, zz, is_, ms);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL random cycle %0d: got %h expected %h", i, a, e); end
            i++;
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] a;
        do_reset();
        set_in(0, 6'b100011, 6'b000000, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        a = sample(0);
        n_checks++;
        if (a[W-1 -: 3] !== 3'd2) begin
            n_fail++; $display("FAIL mid_reset pre state: got %0d expected 2", a[W-1 -: 3]);
        end
        #1 rst_n = 1'b0;
        #1;
        a = sample(0);
        n_checks++;
        if (a !== '0) begin
            n_fail++; $display("FAIL mid_reset async: got %h expected %h", a, {W{1'b0}});
        end
        @(negedge clk);
        do_reset();
        run(0, K_ADD, 1'b0, 0, 0);
        a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
        n_checks++;
        if (a !== exp_q[0]) begin
            n_fail++; $display("FAIL mid_reset refetch: got %h expected %h", a, exp_q[0]);
        end
        exp_q.delete();
        act_q.delete();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mem_stall();
        test_branch_jump();
        test_timeout();
        test_illegal();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
